// File: rtl/adc_pkg.sv
// Frame layout shared with the SPI ADC acquisition core, plus decimator helpers.
// Any consumer of raw conversion frames imports this so the format is defined once.
package adc_pkg;

   localparam int ADC_DATA_WIDTH   = 32;
   localparam int ADC_SAMPLE_WIDTH = 24;
   localparam int ADC_SAMPLE_MSB   = ADC_DATA_WIDTH - 1;
   localparam int ADC_SAMPLE_LSB   = ADC_DATA_WIDTH - ADC_SAMPLE_WIDTH;
   localparam int ADC_AUX_WIDTH    = ADC_SAMPLE_LSB;
   localparam int ADC_MAX_LOG2_DEC = 8;

   // Width of the log2 ratio control field.
   localparam int LOG2_W = 4;

   function automatic logic [LOG2_W-1:0] clamp_log2(input logic [LOG2_W-1:0] req,
                                                    input logic [LOG2_W-1:0] max_l);
      return (req > max_l) ? max_l : req;
   endfunction

endpackage

// File: rtl/adc_sample_extract.sv
// Pulls the signed sample field out of a raw conversion frame and sign-extends it
// to the requested width; the aux/common-mode LSBs are shifted away.
module adc_sample_extract
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH   = ADC_DATA_WIDTH,
   parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
   parameter int ACC_WIDTH    = ADC_SAMPLE_WIDTH + ADC_MAX_LOG2_DEC
) (
   input  logic        [DATA_WIDTH-1:0] frame,
   output logic signed [ACC_WIDTH-1:0]  sample
);

   logic signed [DATA_WIDTH-1:0] aligned;

   // Arithmetic shift keeps the sample's sign while dropping the aux bits.
   assign aligned = $signed(frame) >>> (DATA_WIDTH - SAMPLE_WIDTH);
   assign sample  = ACC_WIDTH'(aligned);

endmodule

// File: rtl/axis_adc_decimator.sv
// Boxcar decimator: sums 2^L signed ADC samples and emits the floor-average
// on an AXI-Stream master through a single output register.
module axis_adc_decimator
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH   = ADC_DATA_WIDTH,
   parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
   parameter int MAX_LOG2_DEC = ADC_MAX_LOG2_DEC
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [LOG2_W-1:0]       log2_dec,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [MAX_LOG2_DEC:0]   block_count
);

   localparam int ACC_W = SAMPLE_WIDTH + MAX_LOG2_DEC;
   localparam int CNT_W = MAX_LOG2_DEC + 1;

   logic [LOG2_W-1:0]       l_lat;
   logic [LOG2_W-1:0]       l_req;
   logic [LOG2_W-1:0]       l_next;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sample;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] shifted;
   logic [CNT_W-1:0]        block_target;
   logic                    block_ending;
   logic                    accept;

   adc_sample_extract #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .ACC_WIDTH    (ACC_W)
   ) u_extract (
      .frame  (s_axis_tdata),
      .sample (sample)
   );

   assign l_req = clamp_log2(log2_dec, LOG2_W'(MAX_LOG2_DEC));

   // The ratio in force for the sample on the bus: a block not yet started
   // uses the live request, a block in progress keeps the one it latched.
   assign l_next       = (block_count == '0) ? l_req : l_lat;
   assign block_target = CNT_W'(1) << l_next;
   assign block_ending = (block_count + CNT_W'(1)) == block_target;

   assign sum     = acc + sample;
   assign shifted = sum >>> l_next;

   // Only a block-ending sample needs the output slot, so only it can stall.
   assign s_axis_tready = aresetn & ~(block_ending & m_axis_tvalid & ~m_axis_tready);
   assign accept        = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         acc         <= '0;
         block_count <= '0;
         l_lat       <= '0;
      end else if (accept) begin
         if (block_count == '0) begin
            l_lat <= l_req;
         end
         if (block_ending) begin
            acc         <= '0;
            block_count <= '0;
         end else begin
            acc         <= sum;
            block_count <= block_count + CNT_W'(1);
         end
      end
   end

   // Reload takes priority over drain so a same-cycle drain/reload keeps tvalid high.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
      end else if (accept && block_ending) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= DATA_WIDTH'(shifted);
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Directed bench for axis_adc_decimator: expected averages go into a queue when
// stimulus is issued; a monitor pops and compares on every output handshake.
module tb_axis_adc_decimator;

   logic        aclk;
   logic        aresetn;
   logic [3:0]  log2_dec;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [8:0]  block_count;

   logic [31:0] exp_q[$];
   int          tests_run;
   int          tests_failed;

   axis_adc_decimator dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .log2_dec      (log2_dec),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .block_count   (block_count)
   );

   // Clock and reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Present one frame and hold it until the DUT takes it; returns #1 after the accepting edge.
   task automatic send(input logic [31:0] frame);
      bit ok;
      ok = 1'b0;
      s_axis_tdata  = frame;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         if (s_axis_tready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: frame %h not accepted within 50 cycles", frame);
      end
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   // Scoreboard monitor: inputs change only #1 after posedge, so the negedge view is what the next edge sees.
   always @(negedge aclk) begin
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL out_unexpected: got %h, expected no output", m_axis_tdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (m_axis_tdata !== e) begin
               tests_failed++;
               $display("FAIL out_data: got %h, expected %h", m_axis_tdata, e);
            end
         end
      end
   end

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      aresetn       = 1'b0;
      log2_dec      = 4'd0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      tick();
      tick();
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tdata", m_axis_tdata, 32'h0);
      check("rst_count", 32'(block_count), 32'd0);
      aresetn = 1'b1;
      tick();

      // L=0 pass-through, output visible one cycle after accept
      log2_dec = 4'd0;
      exp_q.push_back(32'h00000012);
      exp_q.push_back(32'hFFFFFFFF);
      send(32'h00001200);
      check("l0_lat_valid", 32'(m_axis_tvalid), 32'd1);
      check("l0_lat_data", m_axis_tdata, 32'h00000012);
      send(32'hFFFFFF00);
      check("l0_lat_data2", m_axis_tdata, 32'hFFFFFFFF);
      tick();
      check("l0_drained", 32'(m_axis_tvalid), 32'd0);

      // L=2: 1+2+3+4 = 10, >>>2 = 2
      log2_dec = 4'd2;
      exp_q.push_back(32'h00000002);
      send(32'h00000100);
      check("l2_count1", 32'(block_count), 32'd1);
      send(32'h00000200);
      check("l2_count2", 32'(block_count), 32'd2);
      send(32'h00000300);
      check("l2_count3", 32'(block_count), 32'd3);
      check("l2_no_early_out", 32'(m_axis_tvalid), 32'd0);
      send(32'h00000400);
      check("l2_count0", 32'(block_count), 32'd0);
      tick();

      // L=1: (-3 + 0) >>> 1 = -2 (floor)
      log2_dec = 4'd1;
      exp_q.push_back(32'hFFFFFFFE);
      send(32'hFFFFFD00);
      send(32'h00000000);
      tick();

      // L=8, 256 x max-negative: no wrap
      log2_dec = 4'd8;
      exp_q.push_back(32'hFF800000);
      for (int i = 0; i < 256; i++) send(32'h80000000);
      tick();

      // Requests above 8 clamp to 8: 256 samples of 1 -> 1
      log2_dec = 4'd15;
      exp_q.push_back(32'h00000001);
      for (int i = 0; i < 255; i++) send(32'h00000100);
      check("clamp_count", 32'(block_count), 32'd255);
      send(32'h00000100);
      tick();

      // Backpressure, L=0
      log2_dec      = 4'd0;
      m_axis_tready = 1'b0;
      exp_q.push_back(32'h00000005);
      exp_q.push_back(32'h00000006);
      send(32'h00000500);
      s_axis_tdata  = 32'h00000600;
      s_axis_tvalid = 1'b1;
      tick();
      check("bp_tready", 32'(s_axis_tready), 32'd0);
      check("bp_hold_data", m_axis_tdata, 32'h00000005);
      tick();
      check("bp_hold_data2", m_axis_tdata, 32'h00000005);
      check("bp_hold_valid", 32'(m_axis_tvalid), 32'd1);
      m_axis_tready = 1'b1;
      #1;
      check("bp_release_tready", 32'(s_axis_tready), 32'd1);
      tick();
      s_axis_tvalid = 1'b0;
      check("bp_reload_valid", 32'(m_axis_tvalid), 32'd1);
      check("bp_reload_data", m_axis_tdata, 32'h00000006);
      tick();
      check("bp_drained", 32'(m_axis_tvalid), 32'd0);

      // Ratio change mid-block: 4+8+12+16 = 40 >>> 2 = 10, then pass-through 7
      log2_dec = 4'd2;
      exp_q.push_back(32'h0000000A);
      exp_q.push_back(32'h00000007);
      send(32'h00000400);
      send(32'h00000800);
      log2_dec = 4'd0;
      send(32'h00000C00);
      check("chg_count3", 32'(block_count), 32'd3);
      send(32'h00001000);
      check("chg_count0", 32'(block_count), 32'd0);
      send(32'h00000700);
      check("chg_pass_data", m_axis_tdata, 32'h00000007);
      tick();

      // Reset mid-block with a pending output; pending 9 is discarded
      m_axis_tready = 1'b0;
      log2_dec      = 4'd0;
      send(32'h00000900);
      log2_dec = 4'd2;
      send(32'h00000100);
      send(32'h00000200);
      send(32'h00000300);
      check("rst_pre_count", 32'(block_count), 32'd3);
      aresetn = 1'b0;
      tick();
      check("rst2_tready", 32'(s_axis_tready), 32'd0);
      check("rst2_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst2_tdata", m_axis_tdata, 32'h0);
      check("rst2_count", 32'(block_count), 32'd0);
      aresetn       = 1'b1;
      m_axis_tready = 1'b1;
      // 20+20+20+24 = 84 >>> 2 = 21
      exp_q.push_back(32'h00000015);
      send(32'h00001400);
      send(32'h00001400);
      send(32'h00001400);
      send(32'h00001800);
      check("post_rst_data", m_axis_tdata, 32'h00000015);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axis_adc_decimator.md
# axis_adc_decimator

Streaming boxcar decimator that sits directly downstream of the SPI ADC acquisition core. It consumes the raw 32-bit conversion frames on AXI-Stream and extracts the signed sample from each frame. It sums 2^log2_dec consecutive samples and emits the floor-average as one sign-extended word on an AXI-Stream master toward the DMA/packetiser. Decimation ratio is run-time configurable, and changes take effect only at block boundaries.

## Interface
Parameters:
- DATA_WIDTH, 32, width of input frames and output words.
- SAMPLE_WIDTH, 24, signed sample field width; field is frame bits [DATA_WIDTH-1 : DATA_WIDTH-SAMPLE_WIDTH]; remaining LSBs (aux/common-mode) are ignored.
- MAX_LOG2_DEC, 8, largest supported log2 decimation ratio; sets accumulator width SAMPLE_WIDTH+MAX_LOG2_DEC.

Ports:
- aclk  in  1  single clock for everything.
- aresetn  in  1  reset; synchronous and active-low.
- log2_dec  in  4  requested log2 ratio; values above MAX_LOG2_DEC clamp to MAX_LOG2_DEC.
- s_axis_tdata  in  DATA_WIDTH  raw conversion frame.
- s_axis_tvalid  in  1  frame valid.
- s_axis_tready  out  1  decimator can accept a frame.
- m_axis_tdata  out  DATA_WIDTH  averaged sample, sign-extended.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- block_count  out  MAX_LOG2_DEC+1  samples accumulated in the current block (debug/status).

## Operation
- Accept rule: a frame is taken on any rising aclk edge where s_axis_tvalid & s_axis_tready.
- Extraction: sample = signed frame[DATA_WIDTH-1 -: SAMPLE_WIDTH].
- Ratio latch: the active ratio L = min(log2_dec, MAX_LOG2_DEC) is latched when the first sample of a block is accepted, i.e. when block_count == 0. log2_dec changes mid-block are ignored until the next block.
- Accumulation: acc <= acc + sample, sign-extended to SAMPLE_WIDTH+MAX_LOG2_DEC bits. Overflow is impossible by construction.
- Block end: the accepted sample makes block_count+1 == 2^L.
  - out_reg <= (acc + sample) >>> L, arithmetic shift (floor), sign-extended to DATA_WIDTH.
  - m_axis_tvalid is set.
  - acc and block_count return to 0.
- L = 0: pass-through. Every sample is its own block.
- Output slot: one output register.
  - m_axis_tvalid clears on the m_axis_tvalid & m_axis_tready handshake, unless a new block completes in the same cycle; in that case the register is reloaded and tvalid stays 1.
  - m_axis_tdata holds stable while tvalid is high and tready is low.
- Backpressure: s_axis_tready = aresetn & ~(block_ending & m_axis_tvalid & ~m_axis_tready), where block_ending means block_count+1 == 2^L_next and L_next is the latched L, or the clamped log2_dec when block_count == 0.
  - Non-ending samples are always accepted.
  - No sample is ever dropped.
- States (implicit): IDLE (block_count==0), ACCUM (0<block_count<2^L), output FULL/EMPTY is independent.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, block_count 0, acc 0, latched L 0; s_axis_tready 0 while aresetn low.
- Reset mid-block discards the partial sum and any pending output.
- Latency: the block-completing sample accepted at edge t gives m_axis_tvalid=1 and valid data after edge t; it is visible in cycle t+1.
- Throughput: one sample per cycle sustained when downstream is ready. For L=0, one output per cycle with simultaneous drain/reload.
- s_axis_tready is combinational from m_axis_tvalid, m_axis_tready and internal state. It has no combinational dependency on s_axis_tvalid.

## Structure
- Shared package/header `adc_pkg`:
  - frame layout constants: SAMPLE_WIDTH, sample field MSB/LSB, aux field width;
  - DATA_WIDTH default.
  - These are shared with the SPI acquisition core so the frame format is defined once.
- One sub-module is natural: `adc_sample_extract`, combinational field select + sign-extension to accumulator width. Used here and reusable by other consumers.
- The accumulator, ratio latch and output slot stay in the top module.

## Test plan
- L=0, frames 0x00001200, 0xFFFFFF00, m_axis_tready=1 -> outputs 0x00000012, 0xFFFFFFFF, one cycle after each accept.
- L=2, sample fields 1, 2, 3, 4 (frames 0x00000100…0x00000400) -> single output 0x00000002 (10>>>2). block_count sequence 1, 2, 3, 0.
- L=1, sample fields -3, 0 -> output 0xFFFFFFFE (floor of -1.5). Max-negative 0x800000 ×256 at L=8 -> 0xFF800000, with no wrap.
- Backpressure, L=0: hold m_axis_tready=0 with an output pending -> s_axis_tready=0 and the pending data is unchanged. Release -> one drain and one reload in the same cycle; no frame lost.
- Change log2_dec from 2 to 0 after 2 of 4 samples -> the current block still completes at 4 samples; the next block passes through.
- Assert aresetn=0 for one cycle after 3 of 4 samples with an output pending -> all outputs return to reset values. The next 4 samples produce their average only.
